param_fetch_unit: RTL and testbench
===================================

PARAM_FETCH_UNIT -- requirements
Module: param_fetch_unit

Interface
- REQ-001: Parameter FETCH_W, default 4, instructions per fetch bundle; power of 2, 1..8.
- REQ-002: Parameter PC_W, default 16, PC width in bits.
- REQ-003: Parameter INST_W, default 16, instruction width in bits.
- REQ-004: Parameter FQ_DEPTH, default 8, fetch-queue depth in bundles; power of 2, at least 2.
- REQ-005: Port clk, input, 1, the only clock; all logic is rising-edge.
- REQ-006: Port rst, input, 1, synchronous, active-high reset.
- REQ-007: Port boot_pc_en / boot_pc, input, 1 / PC_W, load start PC, accepted in IDLE only.
- REQ-008: Port rob_redirect / rob_pc, input, 1 / PC_W, misprediction recovery: flush, then refetch.
- REQ-009: Port bp_redirect / bp_pc, input, 1 / PC_W, predicted-taken target for the next fetch; no flush.
- REQ-010: Port imem_req_valid / imem_req_ready / imem_req_addr, out / in / out, 1 / 1 / PC_W, bundle-aligned fetch request.
- REQ-011: Port imem_rsp_valid / imem_rsp_data, input, 1 / FETCH_W*INST_W, response; lane i holds the instruction at addr+i.
- REQ-012: Port dec_valid / dec_ready, out / in, 1 / 1, bundle handshake to DECODE.
- REQ-013: Port dec_pc / dec_inst / dec_mask, output, FETCH_W*PC_W / FETCH_W*INST_W / FETCH_W, per-lane PC, instruction and valid mask.

Function
- REQ-014: The FSM states are IDLE, REQ, WAIT and SQUASH.
- REQ-015: IDLE goes to REQ on boot_pc_en, loading pc=boot_pc.
- REQ-016: In REQ, imem_req_valid is asserted only when fq_count + outstanding < FQ_DEPTH.
- REQ-017: In REQ, imem_req_addr = pc with the low log2(FETCH_W) bits cleared.
- REQ-018: A request is accepted on imem_req_valid&&imem_req_ready; the FSM then goes to WAIT with one request outstanding and at most one outstanding.
- REQ-019: In WAIT, imem_rsp_valid enqueues {lane PCs, data, mask} and returns the FSM to REQ with pc = aligned pc + FETCH_W, wrapping modulo 2^PC_W.
- REQ-020: Mask bit i is 1 iff i >= pc[log2(FETCH_W)-1:0] at request time.
- REQ-021: rob_redirect in any non-IDLE state clears the queue the same cycle and sets pc=rob_pc.
- REQ-022: After rob_redirect, the FSM goes to SQUASH if a request is outstanding and no response arrives that cycle; otherwise it goes to REQ.
- REQ-023: bp_redirect sets pc=bp_pc and leaves queued bundles intact.
- REQ-024: bp_redirect squashes an outstanding request via SQUASH under the same rule as rob_redirect.
- REQ-025: rob_redirect has priority over bp_redirect in the same cycle.
- REQ-026: SQUASH discards the next imem_rsp_valid beat, then goes to REQ.
- REQ-027: A redirect in SQUASH only updates pc; the FSM stays in SQUASH.
- REQ-028: A response arriving in the same cycle as a redirect is discarded.
- REQ-029: The queue is FIFO; dec_valid = queue non-empty.
- REQ-030: The head bundle pops on dec_valid&&dec_ready.
- REQ-031: Simultaneous push and pop with the queue full is legal.
- REQ-032: Push is never attempted when full, which REQ-016 guarantees.
- REQ-033: dec_* outputs hold stable while dec_valid&&!dec_ready.
- REQ-034: The base latency is request accept to dec_valid = response cycle + 1.

Reset
- REQ-035: rst forces state IDLE, pc=0, outstanding=0, queue empty.
- REQ-036: Reset values are imem_req_valid=0, imem_req_addr=0, dec_valid=0, dec_pc=0, dec_inst=0, dec_mask=0.
- REQ-037: rst mid-WAIT drops the in-flight response.
- REQ-038: Any imem_rsp_valid received while in IDLE is ignored.

Configuration
- REQ-039: Macro FETCH_BYPASS_EN is defined: a response arriving with the queue empty and dec_ready=1 is presented on dec_* combinationally in the response cycle and not enqueued.
- REQ-040: Macro FETCH_BYPASS_EN is undefined: every bundle passes through the queue and latency follows REQ-034.

Structure
- REQ-041: Package fetch_pkg holds the state enum, default parameter constants and the bundle struct {pc, inst, mask}.
- REQ-042: Sub-module fetch_queue (parametrised by bundle width and FQ_DEPTH) provides push, pop, flush, count, full and empty; all other logic is in param_fetch_unit.

Verification
- REQ-043: With FETCH_W=4, boot_pc=0x0006 -> imem_req_addr=0x0004 and dec_mask=4'b1100; the next request is 0x0008.
- REQ-044: With dec_ready=0 and FQ_DEPTH=8, after 8 responses imem_req_valid=0 and dec_* are stable; dec_ready=1 for 1 cycle -> exactly one new request is issued.
- REQ-045: rob_redirect to 0x0100 during WAIT -> the queue is empty next cycle, the following response is discarded, and the next request is 0x0100.
- REQ-046: rob_redirect=0x0200 and bp_redirect=0x0300 in the same cycle -> the next request is 0x0200.
- REQ-047: pc=0xFFFC with FETCH_W=4 -> the next request is 0x0000.
- REQ-048: With FETCH_BYPASS_EN, empty queue and dec_ready=1 -> dec_valid=1 in the response cycle.
- REQ-049: Without FETCH_BYPASS_EN, empty queue and dec_ready=1 -> dec_valid=1 one cycle after the response.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the instruction fetch unit.
package fetch_pkg;

  localparam int FETCH_W_DEF  = 4;
  localparam int PC_W_DEF     = 16;
  localparam int INST_W_DEF   = 16;
  localparam int FQ_DEPTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    SQUASH
  } state_t;

  // Bundle layout at default sizing; the top rebuilds the same field order for its own parameters.
  typedef struct packed {
    logic [FETCH_W_DEF*PC_W_DEF-1:0]   pc;
    logic [FETCH_W_DEF*INST_W_DEF-1:0] inst;
    logic [FETCH_W_DEF-1:0]            mask;
  } bundle_t;

endpackage

// File: rtl/fetch_queue.sv
// Power-of-two FIFO of fetch bundles with single-cycle flush.
module fetch_queue #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign count = wr_ptr - rd_ptr;
  assign full  = (count == PW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/param_fetch_unit.sv
// Instruction fetch: issues bundle-aligned imem requests, queues responses for decode.
// Optional FETCH_BYPASS_EN forwards a response straight to decode when the queue is empty.
module param_fetch_unit
  import fetch_pkg::*;
#(
  parameter int FETCH_W  = FETCH_W_DEF,
  parameter int PC_W     = PC_W_DEF,
  parameter int INST_W   = INST_W_DEF,
  parameter int FQ_DEPTH = FQ_DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      boot_pc_en,
  input  logic [PC_W-1:0]           boot_pc,
  input  logic                      rob_redirect,
  input  logic [PC_W-1:0]           rob_pc,
  input  logic                      bp_redirect,
  input  logic [PC_W-1:0]           bp_pc,
  output logic                      imem_req_valid,
  input  logic                      imem_req_ready,
  output logic [PC_W-1:0]           imem_req_addr,
  input  logic                      imem_rsp_valid,
  input  logic [FETCH_W*INST_W-1:0] imem_rsp_data,
  output logic                      dec_valid,
  input  logic                      dec_ready,
  output logic [FETCH_W*PC_W-1:0]   dec_pc,
  output logic [FETCH_W*INST_W-1:0] dec_inst,
  output logic [FETCH_W-1:0]        dec_mask
);

  localparam int CNT_W = $clog2(FQ_DEPTH) + 1;
  localparam int CW1   = CNT_W + 1;
  localparam logic [PC_W-1:0] LOW_MASK = PC_W'(FETCH_W - 1);

  typedef struct packed {
    logic [FETCH_W*PC_W-1:0]   pc;
    logic [FETCH_W*INST_W-1:0] inst;
    logic [FETCH_W-1:0]        mask;
  } lane_bundle_t;

  state_t            state, state_nxt;
  logic [PC_W-1:0]   pc, pc_nxt;
  logic              outstanding, outstanding_nxt;
  logic [PC_W-1:0]   aligned_pc;
  logic [CNT_W-1:0]  fq_count;
  logic [CNT_W:0]    occupancy;
  logic              fq_full, fq_empty;
  logic              redirect, rsp_take, bypass, push, pop, flush, req_fire;
  logic [PC_W-1:0]   redirect_pc;
  lane_bundle_t      rsp_bundle, q_head, out_bundle;

  assign aligned_pc     = pc & ~LOW_MASK;
  assign occupancy      = {1'b0, fq_count} + CW1'(outstanding);
  assign imem_req_valid = (state == REQ) && (occupancy < CW1'(FQ_DEPTH));
  assign imem_req_addr  = aligned_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign redirect    = rob_redirect || bp_redirect;
  assign redirect_pc = rob_redirect ? rob_pc : bp_pc;
  assign rsp_take    = (state == WAIT) && imem_rsp_valid && !redirect;
  assign flush       = rob_redirect && (state != IDLE);

`ifdef FETCH_BYPASS_EN
  assign bypass = rsp_take && fq_empty && dec_ready;
`else
  assign bypass = 1'b0;
`endif

  assign push = rsp_take && !bypass;
  assign pop  = dec_ready && !fq_empty;

  // The pc register is untouched while a request is in flight, so it still describes that request.
  always_comb begin
    rsp_bundle      = '0;
    rsp_bundle.inst = imem_rsp_data;
    for (int i = 0; i < FETCH_W; i++) begin
      rsp_bundle.pc[i*PC_W +: PC_W] = aligned_pc + PC_W'(i);
      rsp_bundle.mask[i]            = (PC_W'(i) >= (pc & LOW_MASK));
    end
  end

  fetch_queue #(
    .W     ($bits(lane_bundle_t)),
    .DEPTH (FQ_DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (rsp_bundle),
    .pop       (pop),
    .flush     (flush),
    .head      (q_head),
    .count     (fq_count),
    .full      (fq_full),
    .empty     (fq_empty)
  );

  assign dec_valid  = !fq_empty || bypass;
  assign out_bundle = bypass ? rsp_bundle : q_head;
  assign dec_pc     = dec_valid ? out_bundle.pc   : '0;
  assign dec_inst   = dec_valid ? out_bundle.inst : '0;
  assign dec_mask   = dec_valid ? out_bundle.mask : '0;

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    outstanding_nxt = outstanding;
    case (state)
      IDLE: begin
        if (boot_pc_en) begin
          state_nxt = REQ;
          pc_nxt    = boot_pc;
        end
      end
      REQ: begin
        if (req_fire) begin
          state_nxt       = redirect ? SQUASH : WAIT;
          outstanding_nxt = 1'b1;
        end
        if (redirect) pc_nxt = redirect_pc;
      end
      WAIT: begin
        if (redirect) begin
          pc_nxt = redirect_pc;
          if (imem_rsp_valid) begin
            state_nxt       = REQ;
            outstanding_nxt = 1'b0;
          end else begin
            state_nxt = SQUASH;
          end
        end else if (imem_rsp_valid) begin
          state_nxt       = REQ;
          pc_nxt          = aligned_pc + PC_W'(FETCH_W);
          outstanding_nxt = 1'b0;
        end
      end
      SQUASH: begin
        if (redirect) pc_nxt = redirect_pc;
        if (imem_rsp_valid) begin
          state_nxt       = REQ;
          outstanding_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= '0;
      outstanding <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      outstanding <= outstanding_nxt;
    end
  end

endmodule

// File: tb/tb_param_fetch_unit.sv
// Directed bench for param_fetch_unit at default sizing (FETCH_W=4, PC_W=16, INST_W=16, FQ_DEPTH=8).
module tb_param_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        boot_pc_en;
  logic [15:0] boot_pc;
  logic        rob_redirect;
  logic [15:0] rob_pc;
  logic        bp_redirect;
  logic [15:0] bp_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [15:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [63:0] imem_rsp_data;
  logic        dec_valid;
  logic        dec_ready;
  logic [63:0] dec_pc;
  logic [63:0] dec_inst;
  logic [3:0]  dec_mask;

  int passed = 0;
  int total  = 0;

  param_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .boot_pc_en     (boot_pc_en),
    .boot_pc        (boot_pc),
    .rob_redirect   (rob_redirect),
    .rob_pc         (rob_pc),
    .bp_redirect    (bp_redirect),
    .bp_pc          (bp_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_pc         (dec_pc),
    .dec_inst       (dec_inst),
    .dec_mask       (dec_mask)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  function automatic logic [63:0] mk_inst(input logic [15:0] a);
    logic [63:0] r;
    for (int i = 0; i < 4; i++) r[i*16 +: 16] = 16'hA000 ^ (a + 16'(i));
    return r;
  endfunction

  function automatic logic [63:0] mk_pc(input logic [15:0] a);
    logic [63:0] r;
    for (int i = 0; i < 4; i++) r[i*16 +: 16] = a + 16'(i);
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    boot_pc_en = 1'b0; boot_pc = '0;
    rob_redirect = 1'b0; rob_pc = '0;
    bp_redirect = 1'b0; bp_pc = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    dec_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic boot(input logic [15:0] a);
    boot_pc_en = 1'b1; boot_pc = a;
    @(negedge clk);
    boot_pc_en = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (imem_req_valid !== 1'b0) $display("FAIL rst_req_valid got %b want 0", imem_req_valid); else passed++;
    total++; if (imem_req_addr !== 16'h0) $display("FAIL rst_req_addr got %h want 0000", imem_req_addr); else passed++;
    total++; if (dec_valid !== 1'b0) $display("FAIL rst_dec_valid got %b want 0", dec_valid); else passed++;
    total++; if ({dec_pc, dec_inst, dec_mask} !== '0) $display("FAIL rst_dec_outputs got %h %h %h want 0", dec_pc, dec_inst, dec_mask); else passed++;
    // stray response in IDLE
    imem_rsp_valid = 1'b1; imem_rsp_data = mk_inst(16'h0);
    @(negedge clk);
    imem_rsp_valid = 1'b0; #1;
    total++; if (dec_valid !== 1'b0) $display("FAIL idle_rsp_ignored got %b want 0", dec_valid); else passed++;
    // reset while a request is in flight
    imem_req_ready = 1'b1;
    boot(16'h0050);
    @(negedge clk);
    rst = 1'b1; imem_rsp_valid = 1'b1; imem_rsp_data = mk_inst(16'h0050);
    @(negedge clk);
    rst = 1'b0; imem_rsp_valid = 1'b0; #1;
    total++; if (dec_valid !== 1'b0) $display("FAIL rst_wait_drop got %b want 0", dec_valid); else passed++;
    total++; if (imem_req_valid !== 1'b0 || imem_req_addr !== 16'h0)
      $display("FAIL rst_wait_req got %b/%h want 0/0000", imem_req_valid, imem_req_addr); else passed++;
  endtask

  task automatic test_boot_align();
    do_reset();
    imem_req_ready = 1'b1;
    boot(16'h0006);
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 16'h0004)
      $display("FAIL boot_req got %b/%h want 1/0004", imem_req_valid, imem_req_addr); else passed++;
    @(negedge clk);
    total++; if (imem_req_valid !== 1'b0) $display("FAIL wait_no_req got %b want 0", imem_req_valid); else passed++;
    imem_rsp_valid = 1'b1; imem_rsp_data = mk_inst(16'h0004); #1;
    total++; if (dec_valid !== 1'b0) $display("FAIL boot_rsp_cycle_dec got %b want 0", dec_valid); else passed++;
    @(negedge clk);
    imem_rsp_valid = 1'b0; #1;
    total++; if (dec_valid !== 1'b1 || dec_mask !== 4'b1100)
      $display("FAIL boot_mask got %b/%b want 1/1100", dec_valid, dec_mask); else passed++;
    total++; if (dec_pc !== mk_pc(16'h0004) || dec_inst !== mk_inst(16'h0004))
      $display("FAIL boot_bundle got %h/%h want %h/%h", dec_pc, dec_inst, mk_pc(16'h0004), mk_inst(16'h0004)); else passed++;
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 16'h0008)
      $display("FAIL boot_next_req got %b/%h want 1/0008", imem_req_valid, imem_req_addr); else passed++;
    dec_ready = 1'b1;
    @(negedge clk);
    dec_ready = 1'b0; #1;
    total++; if (dec_valid !== 1'b0) $display("FAIL boot_pop got %b want 0", dec_valid); else passed++;
  endtask

  task automatic test_backpressure();
    do_reset();
    imem_req_ready = 1'b1;
    boot(16'h0000);
    for (int k = 0; k < 8; k++) begin
      total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 16'(k*4))
        $display("FAIL fill_req[%0d] got %b/%h want 1/%h", k, imem_req_valid, imem_req_addr, 16'(k*4)); else passed++;
      @(negedge clk);
      imem_rsp_valid = 1'b1; imem_rsp_data = mk_inst(16'(k*4));
      @(negedge clk);
      imem_rsp_valid = 1'b0; #1;
    end
    total++; if (imem_req_valid !== 1'b0) $display("FAIL full_no_req got %b want 0", imem_req_valid); else passed++;
    repeat (3) @(negedge clk);
    #1;
    total++; if (dec_valid !== 1'b1 || dec_pc !== mk_pc(16'h0) || dec_inst !== mk_inst(16'h0) || dec_mask !== 4'hF)
      $display("FAIL full_stable got %b/%h/%h/%b want 1/%h/%h/1111", dec_valid, dec_pc, dec_inst, dec_mask, mk_pc(16'h0), mk_inst(16'h0)); else passed++;
    total++; if (imem_req_valid !== 1'b0) $display("FAIL full_hold_no_req got %b want 0", imem_req_valid); else passed++;
    dec_ready = 1'b1;
    @(negedge clk);
    dec_ready = 1'b0; #1;
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 16'h0020)
      $display("FAIL one_slot_req got %b/%h want 1/0020", imem_req_valid, imem_req_addr); else passed++;
    total++; if (dec_pc !== mk_pc(16'h0004)) $display("FAIL pop_next_head got %h want %h", dec_pc, mk_pc(16'h0004)); else passed++;
    @(negedge clk);
    imem_rsp_valid = 1'b1; imem_rsp_data = mk_inst(16'h0020);
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (imem_req_valid !== 1'b0) $display("FAIL refull_no_req got %b want 0", imem_req_valid); else passed++;
  endtask

  task automatic test_rob_redirect();
    do_reset();
    imem_req_ready = 1'b1;
    boot(16'h0010);
    @(negedge clk);
    imem_rsp_valid = 1'b1; imem_rsp_data = mk_inst(16'h0010);
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    @(negedge clk);
    #1;
    total++; if (dec_valid !== 1'b1) $display("FAIL rob_pre_queue got %b want 1", dec_valid); else passed++;
    rob_redirect = 1'b1; rob_pc = 16'h0100;
    @(negedge clk);
    rob_redirect = 1'b0; #1;
    total++; if (dec_valid !== 1'b0 || imem_req_valid !== 1'b0)
      $display("FAIL rob_flush got %b/%b want 0/0", dec_valid, imem_req_valid); else passed++;
    imem_rsp_valid = 1'b1; imem_rsp_data = mk_inst(16'h0014);
    @(negedge clk);
    imem_rsp_valid = 1'b0; #1;
    total++; if (dec_valid !== 1'b0) $display("FAIL rob_discard got %b want 0", dec_valid); else passed++;
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 16'h0100)
      $display("FAIL rob_refetch got %b/%h want 1/0100", imem_req_valid, imem_req_addr); else passed++;
  endtask

  task automatic test_bp_redirect();
    do_reset();
    imem_req_ready = 1'b1;
    boot(16'h0020);
    @(negedge clk);
    imem_rsp_valid = 1'b1; imem_rsp_data = mk_inst(16'h0020);
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    @(negedge clk);
    bp_redirect = 1'b1; bp_pc = 16'h0300;
    @(negedge clk);
    bp_redirect = 1'b0; #1;
    total++; if (dec_valid !== 1'b1 || dec_pc !== mk_pc(16'h0020))
      $display("FAIL bp_queue_intact got %b/%h want 1/%h", dec_valid, dec_pc, mk_pc(16'h0020)); else passed++;
    total++; if (imem_req_valid !== 1'b0) $display("FAIL bp_squash got %b want 0", imem_req_valid); else passed++;
    bp_redirect = 1'b1; bp_pc = 16'h0187;
    @(negedge clk);
    bp_redirect = 1'b0; #1;
    total++; if (imem_req_valid !== 1'b0) $display("FAIL squash_redirect_stay got %b want 0", imem_req_valid); else passed++;
    imem_rsp_valid = 1'b1; imem_rsp_data = mk_inst(16'h0024);
    @(negedge clk);
    imem_rsp_valid = 1'b0; #1;
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 16'h0184)
      $display("FAIL bp_refetch got %b/%h want 1/0184", imem_req_valid, imem_req_addr); else passed++;
    total++; if (dec_pc !== mk_pc(16'h0020)) $display("FAIL bp_discard got %h want %h", dec_pc, mk_pc(16'h0020)); else passed++;
  endtask

  task automatic test_priority();
    do_reset();
    imem_req_ready = 1'b1;
    boot(16'h0100);
    @(negedge clk);
    rob_redirect = 1'b1; rob_pc = 16'h0200;
    bp_redirect = 1'b1; bp_pc = 16'h0300;
    imem_rsp_valid = 1'b1; imem_rsp_data = mk_inst(16'h0100);
    imem_req_ready = 1'b0;
    @(negedge clk);
    rob_redirect = 1'b0; bp_redirect = 1'b0; imem_rsp_valid = 1'b0; #1;
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 16'h0200)
      $display("FAIL prio_req got %b/%h want 1/0200", imem_req_valid, imem_req_addr); else passed++;
    total++; if (dec_valid !== 1'b0) $display("FAIL prio_rsp_discard got %b want 0", dec_valid); else passed++;
  endtask

  task automatic test_wrap();
    do_reset();
    imem_req_ready = 1'b1;
    boot(16'hFFFC);
    total++; if (imem_req_addr !== 16'hFFFC) $display("FAIL wrap_req got %h want fffc", imem_req_addr); else passed++;
    @(negedge clk);
    imem_rsp_valid = 1'b1; imem_rsp_data = mk_inst(16'hFFFC);
    @(negedge clk);
    imem_rsp_valid = 1'b0; #1;
    total++; if (dec_mask !== 4'hF || dec_pc !== mk_pc(16'hFFFC))
      $display("FAIL wrap_bundle got %b/%h want 1111/%h", dec_mask, dec_pc, mk_pc(16'hFFFC)); else passed++;
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 16'h0000)
      $display("FAIL wrap_next got %b/%h want 1/0000", imem_req_valid, imem_req_addr); else passed++;
  endtask

  task automatic test_latency();
    do_reset();
    imem_req_ready = 1'b1;
    dec_ready = 1'b1;
    boot(16'h0041);
    @(negedge clk);
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = mk_inst(16'h0040); #1;
`ifdef FETCH_BYPASS_EN
    total++; if (dec_valid !== 1'b1 || dec_mask !== 4'b1110 || dec_pc !== mk_pc(16'h0040))
      $display("FAIL bypass_rsp_cycle got %b/%b/%h want 1/1110/%h", dec_valid, dec_mask, dec_pc, mk_pc(16'h0040)); else passed++;
    @(negedge clk);
    imem_rsp_valid = 1'b0; #1;
    total++; if (dec_valid !== 1'b0) $display("FAIL bypass_not_queued got %b want 0", dec_valid); else passed++;
`else
    total++; if (dec_valid !== 1'b0) $display("FAIL lat_rsp_cycle got %b want 0", dec_valid); else passed++;
    @(negedge clk);
    imem_rsp_valid = 1'b0; #1;
    total++; if (dec_valid !== 1'b1 || dec_mask !== 4'b1110 || dec_pc !== mk_pc(16'h0040))
      $display("FAIL lat_next_cycle got %b/%b/%h want 1/1110/%h", dec_valid, dec_mask, dec_pc, mk_pc(16'h0040)); else passed++;
`endif
    @(negedge clk);
    #1;
    total++; if (dec_valid !== 1'b0) $display("FAIL lat_drained got %b want 0", dec_valid); else passed++;
  endtask

  initial begin
    test_reset();
    test_boot_align();
    test_backpressure();
    test_rob_redirect();
    test_bp_redirect();
    test_priority();
    test_wrap();
    test_latency();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
